// File: rtl/countdown_timer_ctrl.sv
// Programmable down-counting timer: valid/ready config, prescaler, start/stop/pause, one-shot or periodic.
// Config is accepted only in IDLE/DONE; done is a registered one-cycle pulse on the edge after expiry.
module countdown_timer_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_load,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_reload,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [WIDTH-1:0]      CNT_ONE  = 1;
    localparam logic [WIDTH-1:0]      CNT_ZERO = '0;
    localparam logic [PRESCALE_W-1:0] PS_ONE   = 1;
    localparam logic [PRESCALE_W-1:0] PS_ZERO  = '0;

    logic [1:0]            r_state;
    logic [WIDTH-1:0]      r_count;
    logic                  r_done;
    logic [WIDTH-1:0]      r_load;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_reload;
    logic [PRESCALE_W-1:0] r_pcnt;

    logic                  w_cfg_ready;
    logic                  w_cfg_xfer;
    logic                  w_tick;
    logic                  w_expire;
    logic [1:0]            w_state_nxt;
    logic [WIDTH-1:0]      w_count_nxt;
    logic                  w_done_nxt;
    logic [WIDTH-1:0]      w_load_nxt;
    logic [PRESCALE_W-1:0] w_presc_nxt;
    logic                  w_reload_nxt;
    logic [PRESCALE_W-1:0] w_pcnt_nxt;

    assign w_cfg_ready = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_cfg_xfer  = cfg_valid && w_cfg_ready;
    // stop and pause both suppress the tick, so a pause on the terminal prescale cycle loses no count
    assign w_tick      = (r_state == S_RUN) && (r_pcnt == r_presc) && !stop && !pause;
    assign w_expire    = w_tick && (r_count == CNT_ZERO);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_done_nxt   = 1'b0;
        w_load_nxt   = r_load;
        w_presc_nxt  = r_presc;
        w_reload_nxt = r_reload;
        w_pcnt_nxt   = r_pcnt;

        if (stop) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = r_load;
            w_pcnt_nxt  = PS_ZERO;
        end else if (w_cfg_xfer) begin
            w_load_nxt   = cfg_load;
            w_presc_nxt  = cfg_prescale;
            w_reload_nxt = cfg_reload;
            w_count_nxt  = cfg_load;
            w_pcnt_nxt   = PS_ZERO;
            w_state_nxt  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                        w_count_nxt = r_load;
                        w_pcnt_nxt  = PS_ZERO;
                    end
                end
                S_PAUSED: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (w_expire) begin
                        w_pcnt_nxt = PS_ZERO;
                        w_done_nxt = 1'b1;
                        if (r_reload) begin
                            w_count_nxt = r_load;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else if (w_tick) begin
                        w_pcnt_nxt  = PS_ZERO;
                        w_count_nxt = r_count - CNT_ONE;
                    end else begin
                        w_pcnt_nxt = r_pcnt + PS_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= CNT_ZERO;
            r_done   <= 1'b0;
            r_load   <= CNT_ZERO;
            r_presc  <= PS_ZERO;
            r_reload <= 1'b0;
            r_pcnt   <= PS_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_done   <= w_done_nxt;
            r_load   <= w_load_nxt;
            r_presc  <= w_presc_nxt;
            r_reload <= w_reload_nxt;
            r_pcnt   <= w_pcnt_nxt;
        end
    end

    assign cfg_ready = w_cfg_ready;
    assign count     = r_count;
    assign done      = r_done;
    assign state     = r_state;
    assign busy      = (r_state == S_RUN) || (r_state == S_PAUSED);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl: vector table plus reload-period and pause sequences.
module tb_countdown_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_load = 4'd0;
    logic [3:0] cfg_prescale = 4'd0;
    logic       cfg_reload = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    countdown_timer_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_load(cfg_load), .cfg_prescale(cfg_prescale), .cfg_reload(cfg_reload),
        .start(start), .stop(stop), .pause(pause),
        .count(count), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       cv;
        logic [3:0] ld;
        logic [3:0] ps;
        logic       rl;
        logic       st;
        logic       sp;
        logic       pa;
        logic [3:0] e_cnt;
        logic [1:0] e_st;
        logic       e_done;
        logic       e_rdy;
        logic       e_busy;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic vec_t mk(logic rst_n, logic cv, logic [3:0] ld, logic [3:0] ps, logic rl,
                                logic st, logic sp, logic pa,
                                logic [3:0] e_cnt, logic [1:0] e_st, logic e_done, logic e_rdy, logic e_busy);
        vec_t v;
        v.rst_n = rst_n; v.cv = cv; v.ld = ld; v.ps = ps; v.rl = rl;
        v.st = st; v.sp = sp; v.pa = pa;
        v.e_cnt = e_cnt; v.e_st = e_st; v.e_done = e_done; v.e_rdy = e_rdy; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step(input logic rst_n, input logic cv, input logic [3:0] ld, input logic [3:0] ps,
                        input logic rl, input logic st, input logic sp, input logic pa);
        @(negedge clk);
        reset = rst_n; cfg_valid = cv; cfg_load = ld; cfg_prescale = ps; cfg_reload = rl;
        start = st; stop = sp; pause = pa;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] e_cnt, input logic [1:0] e_st,
                           input logic e_done, input logic e_rdy, input logic e_busy);
        chk({tag, ".count"}, idx, 32'(count), 32'(e_cnt));
        chk({tag, ".state"}, idx, 32'(state), 32'(e_st));
        chk({tag, ".done"}, idx, 32'(done), 32'(e_done));
        chk({tag, ".cfg_ready"}, idx, 32'(cfg_ready), 32'(e_rdy));
        chk({tag, ".busy"}, idx, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rel_cnt [6];
        logic [3:0] pau_cnt [11];
        logic [1:0] pau_st  [11];

        //                  rst cv ld    ps    rl st sp pa   cnt   st  dn rdy bsy
        vecs[0]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd0, 2'd0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd0, 2'd0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 4'd3, 4'd0, 0, 0, 0, 0,  4'd3, 2'd0, 0, 1, 0);
        vecs[3]  = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd3, 2'd1, 0, 0, 1);
        vecs[4]  = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd2, 2'd1, 0, 0, 1);
        vecs[5]  = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd1, 2'd1, 0, 0, 1);
        vecs[6]  = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd0, 2'd1, 0, 0, 1);
        vecs[7]  = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd0, 2'd3, 1, 1, 0);
        vecs[8]  = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd0, 2'd3, 0, 1, 0);
        vecs[9]  = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd3, 2'd1, 0, 0, 1);
        vecs[10] = mk(1, 0, 4'd0, 4'd0, 0, 1, 1, 1,  4'd3, 2'd0, 0, 1, 0);
        vecs[11] = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd3, 2'd1, 0, 0, 1);
        vecs[12] = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd2, 2'd1, 0, 0, 1);
        vecs[13] = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 1,  4'd2, 2'd2, 0, 0, 1);
        vecs[14] = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 1,  4'd2, 2'd2, 0, 0, 1);
        vecs[15] = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd2, 2'd1, 0, 0, 1);
        vecs[16] = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd1, 2'd1, 0, 0, 1);
        vecs[17] = mk(1, 0, 4'd0, 4'd0, 0, 0, 1, 0,  4'd3, 2'd0, 0, 1, 0);
        vecs[18] = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd3, 2'd1, 0, 0, 1);
        vecs[19] = mk(1, 1, 4'd9, 4'd0, 0, 0, 0, 0,  4'd2, 2'd1, 0, 0, 1);
        vecs[20] = mk(1, 1, 4'd9, 4'd0, 0, 0, 1, 0,  4'd3, 2'd0, 0, 1, 0);
        vecs[21] = mk(1, 1, 4'd9, 4'd0, 0, 0, 0, 0,  4'd9, 2'd0, 0, 1, 0);
        vecs[22] = mk(1, 1, 4'd7, 4'd0, 0, 0, 0, 0,  4'd7, 2'd0, 0, 1, 0);
        vecs[23] = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd7, 2'd1, 0, 0, 1);
        vecs[24] = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd6, 2'd1, 0, 0, 1);
        vecs[25] = mk(0, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd0, 2'd0, 0, 1, 0);
        vecs[26] = mk(1, 0, 4'd0, 4'd0, 0, 1, 0, 0,  4'd0, 2'd1, 0, 0, 1);
        vecs[27] = mk(1, 0, 4'd0, 4'd0, 0, 0, 0, 0,  4'd0, 2'd3, 1, 1, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst_n, vecs[i].cv, vecs[i].ld, vecs[i].ps, vecs[i].rl,
                 vecs[i].st, vecs[i].sp, vecs[i].pa);
            chk_all("vec", i, vecs[i].e_cnt, vecs[i].e_st, vecs[i].e_done, vecs[i].e_rdy, vecs[i].e_busy);
        end

        // Periodic mode, L=2 P=1: count sequence per edge after start, period 6.
        rel_cnt[0] = 4'd2; rel_cnt[1] = 4'd2; rel_cnt[2] = 4'd1;
        rel_cnt[3] = 4'd1; rel_cnt[4] = 4'd0; rel_cnt[5] = 4'd0;
        step(1, 1, 4'd2, 4'd1, 1, 0, 0, 0);
        chk("rel.cfg_count", 0, 32'(count), 32'd2);
        step(1, 0, 4'd0, 4'd0, 0, 1, 0, 0);
        chk_all("rel.start", 0, 4'd2, 2'd1, 0, 0, 1);
        for (int k = 1; k <= 19; k++) begin
            step(1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
            chk_all("rel", k, rel_cnt[k % 6], 2'd1, ((k % 6) == 0), 0, 1);
        end
        step(1, 0, 4'd0, 4'd0, 0, 0, 1, 0);
        chk_all("rel.stop", 0, 4'd2, 2'd0, 0, 1, 0);

        // One-shot L=5 P=0, paused at count 3; four edges without decrement move done from edge 6 to 10.
        pau_cnt[0] = 4'd5; pau_st[0] = 2'd1;
        pau_cnt[1] = 4'd4; pau_st[1] = 2'd1;
        pau_cnt[2] = 4'd3; pau_st[2] = 2'd1;
        pau_cnt[3] = 4'd3; pau_st[3] = 2'd2;
        pau_cnt[4] = 4'd3; pau_st[4] = 2'd2;
        pau_cnt[5] = 4'd3; pau_st[5] = 2'd2;
        pau_cnt[6] = 4'd3; pau_st[6] = 2'd1;
        pau_cnt[7] = 4'd2; pau_st[7] = 2'd1;
        pau_cnt[8] = 4'd1; pau_st[8] = 2'd1;
        pau_cnt[9] = 4'd0; pau_st[9] = 2'd1;
        pau_cnt[10] = 4'd0; pau_st[10] = 2'd3;
        step(1, 1, 4'd5, 4'd0, 0, 0, 0, 0);
        for (int k = 0; k <= 10; k++) begin
            step(1, 0, 4'd0, 4'd0, 0, (k == 0) || (k == 6), 0, (k == 3));
            chk("pau.count", k, 32'(count), 32'(pau_cnt[k]));
            chk("pau.state", k, 32'(state), 32'(pau_st[k]));
            chk("pau.done", k, 32'(done), 32'(k == 10));
        end
        step(1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
        chk_all("pau.after", 0, 4'd0, 2'd3, 0, 1, 0);

        // Load 0 with reload and P=0: every run cycle expires.
        step(1, 1, 4'd0, 4'd0, 1, 0, 0, 0);
        step(1, 0, 4'd0, 4'd0, 0, 1, 0, 0);
        chk_all("z.start", 0, 4'd0, 2'd1, 0, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
            chk_all("z", k, 4'd0, 2'd1, 1, 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
